// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types, constants and helpers
package uart_pkg;

  localparam int OVERSAMPLE_C = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_DONE
  } uart_rx_state_e;

  // Field order mirrors the control register shared with the TX engine.
  typedef struct packed {
    logic [7:0] div;
    logic [3:0] data_bits;
    logic       parity_en;
    logic       parity_odd;
    logic       stop2;
  } uart_cfg_t;

  // Data length minus one, clamped to the supported 5..8 bit range.
  function automatic logic [2:0] data_bits_m1(input logic [3:0] raw);
    if (raw < 4'd4) begin
      return 3'd4;
    end else if (raw > 4'd7) begin
      return 3'd7;
    end else begin
      return raw[2:0];
    end
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - divisor counter producing one oversample tick every div+1 clocks
module uart_baud_tick
  import uart_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       phase_rst,
  input  logic [7:0] div,
  output logic       tick
);

  logic [7:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || !en || phase_rst) begin
      cnt <= '0;
    end else if (cnt == div) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 8'd1;
    end
  end

  assign tick = en && !phase_rst && (cnt == div);

endmodule

// File: rtl/uart_rx_core.sv
// rtl/uart_rx_core.sv - 16x oversampling UART receive engine with valid/ready byte output
// Optional: define UART_RX_MAJORITY_EN for 2-of-3 voting over ticks 6, 7 and 8.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = OVERSAMPLE_C
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       cfg_en,
  input  logic [7:0] cfg_div,
  input  logic [3:0] cfg_data_bits,
  input  logic       cfg_parity_en,
  input  logic       cfg_parity_odd,
  input  logic       cfg_stop2,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  input  logic       err_clr,
  output logic       frame_err,
  output logic       parity_err,
  output logic       overrun_err,
  output logic       break_det,
  output logic       busy
);

  localparam logic [3:0] MID_IDX = 4'(OVERSAMPLE / 2 - 1);

  logic           rx_meta, rx_s, rx_s_d;
  logic           fall, phase_rst, tick;
  logic           sample_pt, bit_val;
  uart_rx_state_e state;
  uart_cfg_t      cfg_in, cfg_q;
  logic [3:0]     tick_idx;
  logic [2:0]     bit_cnt;
  logic [2:0]     nbits_m1;
  logic [7:0]     data_q;
  logic           par_acc, par_bit, stop_cnt, brk;
  logic           stop_sample, set_frame, set_break, set_parity, set_overrun, done;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_s_d  <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      rx_s_d  <= rx_s;
    end
  end

  assign fall      = rx_s_d & ~rx_s;
  assign phase_rst = (state == ST_IDLE) && fall;

  uart_baud_tick u_baud_tick (
    .clk       (clk),
    .rst       (rst),
    .en        (cfg_en),
    .phase_rst (phase_rst),
    .div       (cfg_q.div),
    .tick      (tick)
  );

`ifdef UART_RX_MAJORITY_EN
  logic samp_a, samp_b;

  always_ff @(posedge clk) begin
    if (rst) begin
      samp_a <= 1'b1;
      samp_b <= 1'b1;
    end else if (tick) begin
      if (tick_idx == MID_IDX - 4'd1) samp_a <= rx_s;
      if (tick_idx == MID_IDX) samp_b <= rx_s;
    end
  end

  // Vote is taken on the third sample, so the decision lands one tick after mid-bit.
  assign sample_pt = tick && (tick_idx == MID_IDX + 4'd1);
  assign bit_val   = (samp_a & samp_b) | (samp_a & rx_s) | (samp_b & rx_s);
`else
  assign sample_pt = tick && (tick_idx == MID_IDX);
  assign bit_val   = rx_s;
`endif

  assign cfg_in = '{
    div:        cfg_div,
    data_bits:  cfg_data_bits,
    parity_en:  cfg_parity_en,
    parity_odd: cfg_parity_odd,
    stop2:      cfg_stop2
  };

  assign nbits_m1 = data_bits_m1(cfg_q.data_bits);

  assign stop_sample = cfg_en && (state == ST_STOP) && !brk && sample_pt;
  assign set_frame   = stop_sample && !bit_val;
  // Break: all-zero character, zero parity bit, zero first stop bit.
  assign set_break   = set_frame && !stop_cnt && (data_q == 8'd0) && !par_bit;
  assign set_parity  = cfg_en && (state == ST_PARITY) && sample_pt &&
                       (bit_val != (par_acc ^ cfg_q.parity_odd));
  assign done        = (state == ST_DONE);
  assign set_overrun = done && rx_valid && !rx_ready;
  assign busy        = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      cfg_q    <= '0;
      tick_idx <= '0;
      bit_cnt  <= '0;
      data_q   <= '0;
      par_acc  <= 1'b0;
      par_bit  <= 1'b0;
      stop_cnt <= 1'b0;
      brk      <= 1'b0;
    end else if (!cfg_en) begin
      state    <= ST_IDLE;
      tick_idx <= '0;
      brk      <= 1'b0;
    end else begin
      if (tick) tick_idx <= tick_idx + 4'd1;
      case (state)
        ST_IDLE: begin
          if (fall) begin
            state    <= ST_START;
            cfg_q    <= cfg_in;
            tick_idx <= '0;
            bit_cnt  <= '0;
            data_q   <= '0;
            par_acc  <= 1'b0;
            par_bit  <= 1'b0;
            stop_cnt <= 1'b0;
            brk      <= 1'b0;
          end
        end
        ST_START: begin
          if (sample_pt) state <= bit_val ? ST_IDLE : ST_DATA;
        end
        ST_DATA: begin
          if (sample_pt) begin
            data_q[bit_cnt] <= bit_val;
            par_acc         <= par_acc ^ bit_val;
            if (bit_cnt == nbits_m1) begin
              state <= cfg_q.parity_en ? ST_PARITY : ST_STOP;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
            end
          end
        end
        ST_PARITY: begin
          if (sample_pt) begin
            par_bit <= bit_val;
            state   <= ST_STOP;
          end
        end
        ST_STOP: begin
          // A break holds the FSM here until the line idles, so no false start follows.
          if (brk) begin
            if (rx_s) state <= ST_IDLE;
          end else if (sample_pt) begin
            if (set_break) begin
              brk <= 1'b1;
            end else if (!stop_cnt && cfg_q.stop2) begin
              stop_cnt <= 1'b1;
            end else begin
              state <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      frame_err   <= 1'b0;
      parity_err  <= 1'b0;
      overrun_err <= 1'b0;
      break_det   <= 1'b0;
    end else begin
      if (done) begin
        if (!rx_valid || rx_ready) begin
          rx_data  <= data_q;
          rx_valid <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
      frame_err   <= set_frame   | (frame_err   & ~err_clr);
      parity_err  <= set_parity  | (parity_err  & ~err_clr);
      overrun_err <= set_overrun | (overrun_err & ~err_clr);
      break_det   <= set_break   | (break_det   & ~err_clr);
    end
  end

endmodule

// File: tb/tb_uart_rx_core.sv
// tb/tb_uart_rx_core.sv - directed and randomized self-checking bench for uart_rx_core
module tb_uart_rx_core;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic       cfg_en;
  logic [7:0] cfg_div;
  logic [3:0] cfg_data_bits;
  logic       cfg_parity_en;
  logic       cfg_parity_odd;
  logic       cfg_stop2;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       err_clr;
  logic       frame_err, parity_err, overrun_err, break_det, busy;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int c0     = 0;
  int rise_cyc = -1;
  logic valid_prev = 1'b0;
  int cur_div = 3;

  uart_rx_core dut (
    .clk            (clk),
    .rst            (rst),
    .rx             (rx),
    .cfg_en         (cfg_en),
    .cfg_div        (cfg_div),
    .cfg_data_bits  (cfg_data_bits),
    .cfg_parity_en  (cfg_parity_en),
    .cfg_parity_odd (cfg_parity_odd),
    .cfg_stop2      (cfg_stop2),
    .rx_data        (rx_data),
    .rx_valid       (rx_valid),
    .rx_ready       (rx_ready),
    .err_clr        (err_clr),
    .frame_err      (frame_err),
    .parity_err     (parity_err),
    .overrun_err    (overrun_err),
    .break_det      (break_det),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_valid && !valid_prev) rise_cyc = cyc;
    valid_prev = rx_valid;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic int period();
    return 16 * (cur_div + 1);
  endfunction

  function automatic int nbits_of(input int db);
    if (db < 4) return 5;
    if (db > 7) return 8;
    return db + 1;
  endfunction

  task automatic set_cfg(input int div, input int db, input logic pen, input logic odd, input logic s2);
    cur_div        = div;
    cfg_div        = 8'(div);
    cfg_data_bits  = 4'(db);
    cfg_parity_en  = pen;
    cfg_parity_odd = odd;
    cfg_stop2      = s2;
  endtask

  task automatic mk_frame(input logic [7:0] d, input int n, input logic pen, input logic pbit,
                          input logic s1, input logic s2en, input logic s2b,
                          output logic [15:0] bits, output int nb);
    bits = '0;
    nb   = 1;
    for (int i = 0; i < n; i++) begin
      bits[nb] = d[i];
      nb++;
    end
    if (pen) begin
      bits[nb] = pbit;
      nb++;
    end
    bits[nb] = s1;
    nb++;
    if (s2en) begin
      bits[nb] = s2b;
      nb++;
    end
  endtask

  task automatic send_bits(input logic [15:0] bits, input int nb);
    for (int i = 0; i < nb; i++) begin
      rx = bits[i];
      if (i == 0) c0 = cyc;
      wait_clk(period());
    end
    rx = 1'b1;
  endtask

  task automatic consume_and_clear();
    rx_ready = 1'b1;
    err_clr  = 1'b1;
    wait_clk(1);
    rx_ready = 1'b0;
    err_clr  = 1'b0;
  endtask

  logic [15:0] fb;
  int          fnb;
  logic [7:0]  last_data;

  initial begin
    rx = 1'b1; rst = 1'b1; cfg_en = 1'b1; rx_ready = 1'b0; err_clr = 1'b0;
    set_cfg(3, 7, 1'b0, 1'b0, 1'b0);
    wait_clk(3);
    rst = 1'b0;
    wait_clk(2);

    check("reset_rx_data", 32'(rx_data), 32'h0);
    check("reset_rx_valid", 32'(rx_valid), 32'h0);
    check("reset_frame_err", 32'(frame_err), 32'h0);
    check("reset_parity_err", 32'(parity_err), 32'h0);
    check("reset_overrun_err", 32'(overrun_err), 32'h0);
    check("reset_break_det", 32'(break_det), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);

    // 8N1 at 64 clocks per bit: latency is 9.5 periods plus 4 clocks.
    rise_cyc = -1;
    mk_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, fb, fnb);
    send_bits(fb, fnb);
    wait_clk(4);
    check("a5_latency", 32'(rise_cyc - c0), 32'((2 * 8 + 3) * 8 * (cur_div + 1) + 4));
    check("a5_data", 32'(rx_data), 32'hA5);
    check("a5_valid", 32'(rx_valid), 32'h1);
    check("a5_errs", {28'h0, frame_err, parity_err, overrun_err, break_det}, 32'h0);
    rx_ready = 1'b1;
    wait_clk(1);
    rx_ready = 1'b0;
    check("a5_handshake_clears_valid", 32'(rx_valid), 32'h0);

    // 7 bits, odd parity: 0x41 has two ones, so the correct parity bit is 1.
    set_cfg(3, 6, 1'b1, 1'b1, 1'b0);
    mk_frame(8'h41, 7, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, fb, fnb);
    send_bits(fb, fnb);
    wait_clk(4);
    check("p_ok_data", 32'(rx_data), 32'h41);
    check("p_ok_parity_err", 32'(parity_err), 32'h0);
    check("p_ok_frame_err", 32'(frame_err), 32'h0);
    consume_and_clear();
    mk_frame(8'h41, 7, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, fb, fnb);
    send_bits(fb, fnb);
    wait_clk(4);
    check("p_bad_parity_err", 32'(parity_err), 32'h1);
    check("p_bad_valid", 32'(rx_valid), 32'h1);
    check("p_bad_data", 32'(rx_data), 32'h41);

    // Reset in the middle of the data bits clears everything and delivers nothing.
    set_cfg(3, 7, 1'b0, 1'b0, 1'b0);
    mk_frame(8'h5A, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, fb, fnb);
    for (int i = 0; i < 3; i++) begin
      rx = fb[i];
      wait_clk(period());
    end
    check("mid_busy", 32'(busy), 32'h1);
    rst = 1'b1;
    rx  = 1'b1;
    wait_clk(1);
    rst = 1'b0;
    check("rst_mid_outputs", {15'h0, rx_data, rx_valid, frame_err, parity_err, overrun_err, break_det, busy},
          32'h0);
    wait_clk(12 * period());
    check("rst_mid_no_delivery", 32'(rx_valid), 32'h0);

    // Stop bit low after 0x3C: frame error, character still delivered.
    mk_frame(8'h3C, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, fb, fnb);
    send_bits(fb, fnb);
    wait_clk(4);
    check("fe_frame_err", 32'(frame_err), 32'h1);
    check("fe_data", 32'(rx_data), 32'h3C);
    check("fe_valid", 32'(rx_valid), 32'h1);
    consume_and_clear();
    wait_clk(period());

    // Line held low for two frame times.
    rx = 1'b0;
    wait_clk(20 * period());
    check("brk_break_det", 32'(break_det), 32'h1);
    check("brk_frame_err", 32'(frame_err), 32'h1);
    check("brk_no_valid", 32'(rx_valid), 32'h0);
    check("brk_busy_while_low", 32'(busy), 32'h1);
    rx = 1'b1;
    wait_clk(6);
    check("brk_idle_after_high", 32'(busy), 32'h0);
    wait_clk(period());
    check("brk_stays_idle", 32'(busy), 32'h0);
    consume_and_clear();

    // Two characters with the consumer stalled.
    mk_frame(8'h11, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, fb, fnb);
    send_bits(fb, fnb);
    wait_clk(period());
    mk_frame(8'h22, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, fb, fnb);
    send_bits(fb, fnb);
    wait_clk(period());
    check("ovr_data_kept", 32'(rx_data), 32'h11);
    check("ovr_flag", 32'(overrun_err), 32'h1);
    check("ovr_valid", 32'(rx_valid), 32'h1);
    err_clr = 1'b1;
    wait_clk(1);
    err_clr = 1'b0;
    check("ovr_cleared", 32'(overrun_err), 32'h0);
    rx_ready = 1'b1;
    wait_clk(1);
    rx_ready = 1'b0;

    // Glitch low for 5 ticks: false start.
    rise_cyc = -1;
    rx = 1'b0;
    wait_clk(5 * (cur_div + 1));
    rx = 1'b1;
    wait_clk(2);
    check("glitch_busy_started", 32'(busy), 32'h1);
    wait_clk(period());
    check("glitch_busy_back", 32'(busy), 32'h0);
    check("glitch_no_valid", 32'(rx_valid), 32'h0);
    check("glitch_no_rise", 32'(rise_cyc), 32'hFFFF_FFFF);

    last_data = rx_data;
    for (int f = 0; f < 14; f++) begin
      int         db, n;
      logic       pen, odd, s2, s1, s2b, pbit, exp_brk, exp_fe, exp_pe, exp_par;
      logic [7:0] mask, d;
      set_cfg($urandom_range(0, 3), $urandom_range(0, 15), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      db   = int'(cfg_data_bits);
      pen  = cfg_parity_en;
      odd  = cfg_parity_odd;
      s2   = cfg_stop2;
      n    = nbits_of(db);
      mask = 8'((1 << n) - 1);
      d    = ($urandom_range(0, 3) == 0) ? 8'h00 : (8'($urandom_range(0, 255)) & mask);
      exp_par = (^d) ^ odd;
      pbit = exp_par ^ ($urandom_range(0, 3) == 0);
      s1   = ($urandom_range(0, 3) != 0);
      s2b  = ($urandom_range(0, 3) != 0);
      exp_brk = (d == 8'h00) && (!pen || !pbit) && !s1;
      exp_fe  = !s1 || (s2 && s2b == 1'b0);
      exp_pe  = pen && (pbit != exp_par);
      wait_clk(2);
      mk_frame(d, n, pen, pbit, s1, s2, s2b, fb, fnb);
      send_bits(fb, fnb);
      wait_clk(2 * period());
      if (!exp_brk) last_data = d;
      check($sformatf("rnd%0d_valid", f), 32'(rx_valid), 32'(!exp_brk));
      check($sformatf("rnd%0d_data", f), 32'(rx_data), 32'(last_data));
      check($sformatf("rnd%0d_parity_err", f), 32'(parity_err), 32'(exp_pe));
      check($sformatf("rnd%0d_frame_err", f), 32'(frame_err), 32'(exp_fe));
      check($sformatf("rnd%0d_break_det", f), 32'(break_det), 32'(exp_brk));
      consume_and_clear();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
